// File: rtl/wam_round_sequencer.sv
// Round controller for the whack-a-mole game: drives the light controller
// through setup, ready countdown, play and game-over, and keeps the round score.
module wam_round_sequencer #(
    parameter int TICK_MAX     = 49_999_999,
    parameter int READY_SECS   = 5,
    parameter int TIMED_SECS   = 60,
    parameter int NORMAL_MAX   = 25,
    parameter int EXTENDED_MAX = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [2:0] mode,
    input  logic       extended,
    input  logic [3:0] lives_cfg,
    input  logic       light_on,
    input  logic [3:0] light_pos,
    input  logic       light_change,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic       lc_load_seed,
    output logic       lc_clear,
    output logic       lc_start,
    output logic [1:0] state,
    output logic [2:0] ready_count,
    output logic [5:0] score,
    output logic [5:0] max_hits,
    output logic [3:0] lives_left,
    output logic [5:0] time_left
);

    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MD_NORMAL = 2'd0,
        MD_TIMED  = 2'd1,
        MD_LIVES  = 2'd2
    } mode_t;

    state_t        state_q, state_n;
    mode_t         mode_q, mode_n;
    logic [TW-1:0] tick_cnt_q, tick_cnt_n;
    logic [5:0]    lamp_count_q, lamp_count_n;
    logic          hit_flag_q, hit_flag_n;
    logic          play_d;
    logic [2:0]    ready_n;
    logic [5:0]    score_n, max_hits_n, time_n;
    logic [3:0]    lives_n;
    logic          play_rise, running, tick, hit, round_end, restart;

    assign play_rise = play & ~play_d;
    assign running   = (state_q == ST_WAIT) || (state_q == ST_PLAY);
    assign tick      = running && (tick_cnt_q == TW'(TICK_MAX));
    assign hit       = key_valid & light_on & (key == light_pos) & ~hit_flag_q;
    assign state     = state_q;

    always_comb begin
        state_n      = state_q;
        mode_n       = mode_q;
        lamp_count_n = lamp_count_q;
        hit_flag_n   = hit_flag_q;
        ready_n      = ready_count;
        score_n      = score;
        max_hits_n   = max_hits;
        lives_n      = lives_left;
        time_n       = time_left;
        restart      = 1'b0;

        case (mode_q)
            MD_TIMED: round_end = (time_left == 6'd0);
            MD_LIVES: round_end = (lives_left == 4'd0);
            default:  round_end = (lamp_count_q == max_hits);
        endcase

        case (state_q)
            ST_SETUP: restart = play_rise;
            ST_WAIT: begin
                if (play_rise) begin
                    restart = 1'b1;
                end else if (tick) begin
                    if (ready_count <= 3'd1) begin
                        state_n = ST_PLAY;
                        ready_n = 3'd0;
                    end else begin
                        ready_n = ready_count - 3'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (play_rise) begin
                    restart = 1'b1;
                end else if (round_end) begin
                    state_n = ST_OVER;
                end else begin
                    if (hit) begin
                        if (score != 6'd63) score_n = score + 6'd1;
                        hit_flag_n = 1'b1;
                    end
                    // A hit landing in the same cycle as the window end still saves the life.
                    if (light_change) begin
                        hit_flag_n = 1'b0;
                        if (lamp_count_q != 6'd63) lamp_count_n = lamp_count_q + 6'd1;
                        if (mode_q == MD_LIVES && !hit_flag_q && !hit && lives_left != 4'd0)
                            lives_n = lives_left - 4'd1;
                    end
                    if (mode_q == MD_TIMED && tick && time_left != 6'd0)
                        time_n = time_left - 6'd1;
                end
            end
            ST_OVER: restart = play_rise;
            default: state_n = ST_SETUP;
        endcase

        if (restart) begin
            state_n      = ST_WAIT;
            case (mode)
                3'b010:  mode_n = MD_TIMED;
                3'b001:  mode_n = MD_LIVES;
                default: mode_n = MD_NORMAL;
            endcase
            max_hits_n   = extended ? 6'(EXTENDED_MAX) : 6'(NORMAL_MAX);
            if (lives_cfg == 4'd0)      lives_n = 4'd1;
            else if (lives_cfg > 4'd9)  lives_n = 4'd9;
            else                        lives_n = lives_cfg;
            time_n       = (mode == 3'b010) ? 6'(TIMED_SECS) : 6'd0;
            ready_n      = 3'(READY_SECS);
            score_n      = 6'd0;
            lamp_count_n = 6'd0;
            hit_flag_n   = 1'b0;
        end

        tick_cnt_n = (restart || !running || tick) ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SETUP;
            mode_q       <= MD_NORMAL;
            tick_cnt_q   <= '0;
            lamp_count_q <= 6'd0;
            hit_flag_q   <= 1'b0;
            play_d       <= 1'b0;
            ready_count  <= 3'd0;
            score        <= 6'd0;
            max_hits     <= 6'(NORMAL_MAX);
            lives_left   <= 4'd0;
            time_left    <= 6'd0;
            lc_load_seed <= 1'b1;
            lc_clear     <= 1'b1;
            lc_start     <= 1'b0;
        end else begin
            state_q      <= state_n;
            mode_q       <= mode_n;
            tick_cnt_q   <= tick_cnt_n;
            lamp_count_q <= lamp_count_n;
            hit_flag_q   <= hit_flag_n;
            play_d       <= play;
            ready_count  <= ready_n;
            score        <= score_n;
            max_hits     <= max_hits_n;
            lives_left   <= lives_n;
            time_left    <= time_n;
            lc_load_seed <= (state_n == ST_SETUP);
            lc_clear     <= ~restart;
            lc_start     <= (state_n == ST_PLAY);
        end
    end

endmodule

// File: doc/wam_round_sequencer.md
Name: wam_round_sequencer

Overview:
- Synchronous round controller for the whack-a-mole game: sequences the light controller (seed load, clear, start) through setup, ready countdown, play and game-over.
- Owns all per-round bookkeeping: score, lamp count, lives, timed-mode seconds.
- Replaces combinational hit recording and edge-clocked life logic with a single-clock scorekeeper; sits between the keypad controller, the light controller and the HEX display decoders.

Parameters:
- TICK_MAX, 49_999_999, clk cycles per 1 s tick minus one.
- READY_SECS, 5, ready countdown start value in seconds.
- TIMED_SECS, 60, timed-mode round length in seconds.
- NORMAL_MAX, 25, lamps per round when extended=0.
- EXTENDED_MAX, 50, lamps per round when extended=1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high; clears everything to SETUP
- play  in  1  synchronous level from the start/restart key; block edge-detects the rising edge
- mode  in  3  100 normal, 010 timed, 001 lives; any other value = normal
- extended  in  1  selects EXTENDED_MAX
- lives_cfg  in  4  lives per round, 1..9; 0 treated as 1, >9 treated as 9
- light_on  in  1  a lamp is currently lit
- light_pos  in  4  index 0..8 of the lit lamp, valid while light_on
- light_change  in  1  one-cycle pulse when a lamp window ends
- key_valid  in  1  one-cycle pulse, new debounced keypress
- key  in  4  key index 0..8, valid with key_valid
- lc_load_seed  out  1  seed load to light controller
- lc_clear  out  1  active-high clear to light controller
- lc_start  out  1  light controller enable
- state  out  2  0 SETUP, 1 WAIT, 2 PLAY, 3 OVER
- ready_count  out  3  ready countdown seconds remaining
- score  out  6  hits this round
- max_hits  out  6  latched lamp target
- lives_left  out  4  remaining lives
- time_left  out  6  timed-mode seconds remaining

Behaviour:
- Reset values: state=SETUP, score=0, max_hits=NORMAL_MAX, lives_left=0, time_left=0, ready_count=0, lc_load_seed=1, lc_clear=1, lc_start=0. Internal tick counter, lamp_count, hit_flag and play_d are all 0.
- play_rise = play & ~play_d, registered every cycle.
- Outputs are registered; all updates are visible 1 cycle after the causing input edge.
- The tick counter runs only in WAIT and PLAY. It is cleared on entry to either state. tick = (counter==TICK_MAX), then the counter wraps to 0.

FSM:
- SETUP:
  - lc_load_seed=1, lc_clear=1.
  - play_rise -> WAIT with restart actions: latch mode, max_hits (per extended) and lives_left (lives_cfg clamped); score=0, lamp_count=0, hit_flag=0, ready_count=READY_SECS, time_left=TIMED_SECS if timed else 0.
- WAIT:
  - lc_clear=1.
  - Each tick decrements ready_count.
  - tick with ready_count==1 -> PLAY, and ready_count becomes 0.
  - play_rise -> restart actions again; stay in WAIT.
- PLAY:
  - lc_start=1.
  - Hit: key_valid & light_on & key==light_pos & ~hit_flag -> score+1 (saturate at 63), hit_flag=1.
  - Wrong key, key while no lamp is lit, or a repeat key on an already-hit lamp: ignored, no penalty.
  - light_change: lamp_count+1 and hit_flag=0. In lives mode, if there was no hit for that lamp, lives_left-1 (floor 0).
  - Same-cycle hit and light_change: the hit is counted, no life is lost, hit_flag ends at 0.
  - Timed mode: each tick decrements time_left (floor 0).
  - End conditions, evaluated on the registered values, with priority play_rise > end:
    - normal: lamp_count==max_hits -> OVER
    - timed: time_left==0 -> OVER
    - lives: lives_left==0 -> OVER
  - play_rise -> WAIT with restart actions. One cycle of lc_clear=0 is asserted on the restart cycle.
- OVER:
  - lc_start=0; score, lives_left and time_left are held.
  - play_rise -> WAIT with restart actions.
- lc_clear is 0 for exactly the one restart cycle and 1 in every other cycle. Mode, lives_cfg and extended changes outside restart have no effect.
- Reset asserted mid-round: immediate return to the reset values, independent of clk.

Test Plan:
- Reset, play pulse -> state=WAIT, ready_count=5, lc_clear low 1 cycle. 5 ticks later state=PLAY, ready_count=0 (run with TICK_MAX=9).
- Normal mode, extended=0: 25 light_change pulses, key matching light_pos before 10 of them -> score=10, state=OVER after the 25th pulse.
- Lives mode, lives_cfg=3: 3 unhit lamps -> lives_left 3,2,1,0, then OVER. Key on the same cycle as light_change with a matching key -> no life lost, score+1.
- Double press on the same lamp and a wrong key -> score increments by 1 only; lives unchanged in normal mode.
- Timed mode, TICK_MAX=9, TIMED_SECS=60: 600 cycles in PLAY -> time_left=0, OVER. Play press mid-PLAY -> WAIT, score=0, time_left=60.
- Assert reset during PLAY with score=7 -> asynchronously state=SETUP, score=0, lc_start=0, lc_load_seed=1.
